serial_bit_feeder: RTL and testbench
====================================

Name: serial_bit_feeder

Overview:
- Upstream parallel-to-serial stage for the serial sequence-detector FSM.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on x_out, which drives the FSM's x_in.
- Provides a bit-valid qualifier, a hold (pause) control, and an end-of-word pulse.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8: bits per word; legal range is 2 to 32.
- MSB_FIRST, 1: 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.
- IDLE_LEVEL, 0: value driven on x_out when no word is being shifted.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- load_valid  input  1  producer presents load_data.
- load_data  input  WIDTH  word to serialize.
- load_ready  output  1  block can accept a word this cycle.
- hold  input  1  pauses shifting while high.
- x_out  output  1  serial bit stream (to downstream x_in).
- bit_valid  output  1  x_out carries a real data bit this cycle.
- busy  output  1  a word is in progress (SHIFT state).
- frame_done  output  1  one-cycle pulse on the cycle the last bit is presented.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, shift register=0, bit counter=0, x_out=IDLE_LEVEL, bit_valid=0, busy=0, frame_done=0. Reset mid-word discards the word. After reset releases, the first edge sees IDLE.
- All outputs except load_ready are registered.
- load_ready is combinational: (state==IDLE) OR (state==SHIFT AND cnt==WIDTH-1 AND hold==0). It never depends on load_valid.
- Accept = load_valid AND load_ready, sampled at the rising edge.
- States:
  - IDLE:
    - x_out=IDLE_LEVEL, bit_valid=0, busy=0.
    - On accept: latch load_data, go to SHIFT, cnt=0. The next cycle presents the first bit (latency of 1 clock from accept edge to first bit).
    - hold is ignored in IDLE.
  - SHIFT:
    - x_out = current bit (MSB_FIRST ? data[WIDTH-1-cnt] : data[cnt]).
    - bit_valid = NOT hold_registered, where hold_registered is hold sampled at the previous edge.
    - busy=1.
- Hold, sampled at each edge while in SHIFT:
  - hold=1: cnt, shift register and x_out frozen; next cycle bit_valid=0 and frame_done=0.
  - On release, the same bit is re-presented with bit_valid=1. No bit is lost or duplicated as a valid bit.
- Advance: at an edge in SHIFT with hold=0:
  - If cnt<WIDTH-1: cnt increments and the next bit is presented.
  - If cnt==WIDTH-1 (last bit on wire):
    - With accept: reload, cnt=0, and present the new word's first bit next cycle. Zero gap; busy stays 1.
    - Without accept: go to IDLE, x_out=IDLE_LEVEL, bit_valid=0.
- frame_done=1 exactly on cycles where the last bit (cnt==WIDTH-1) is presented with bit_valid=1. Exactly one pulse per word, even if hold stretched the last bit.
- load_data changes while not accepted are ignored. A word is captured only on accept; the serialized word is immune to later load_data changes.
- A word of all IDLE_LEVEL bits is still a full WIDTH-cycle frame: bit_valid=1 and busy=1 throughout.
- Counter width: clog2(WIDTH). cnt never exceeds WIDTH-1.

Test Plan:
- Reset/idle: hold reset low 3 cycles with load_valid=1 → x_out=0, bit_valid=0, busy=0, frame_done=0, no word captured. Release reset → load_ready=1.
- MSB-first word (WIDTH=8): accept 8'hB4 at edge T → cycles T+1..T+8: x_out=1,0,1,1,0,1,0,0 with bit_valid=1. frame_done=1 only at T+8. T+9: x_out=0, busy=0.
- LSB-first word (MSB_FIRST=0): accept 8'hB4 → x_out=0,0,1,0,1,1,0,1. Downstream FSM fed from x_out is checked against its expected y_out trace.
- Back-to-back: load_valid held high with 8'hFF then 8'h00 → 16 consecutive bit_valid cycles with no gap (eight 1s, eight 0s). load_ready high only at cycles 8 and 16 of the stream. frame_done pulses twice.
- Hold: accept 8'hA5, assert hold for 3 edges during bit 3 and for 2 edges during bit 7 → x_out frozen, bit_valid=0 during holds, load_ready=0 while hold is high on the last bit. Valid-bit sequence is still 1,0,1,0,0,1,0,1 with a single frame_done pulse.
- Reset mid-word: accept 8'hC3, pull reset low after 4 bits → outputs immediately return to reset values. After release, a new word 8'h81 serializes cleanly from its first bit.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the sequence-detector FSM.
// Takes words over valid/ready and emits one bit per clock with pause support.
module serial_bit_feeder #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             hold,
  output logic             x_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             fd_q, fd_d;
  logic             last;
  logic             accept;

  always_comb begin
    last       = (state_q == SHIFT) && (cnt_q == LAST);
    load_ready = (state_q == IDLE) || (last && !hold);
    accept     = load_valid && load_ready;

    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sr_d    = load_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!hold) begin
          if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
            sr_d  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
          end else if (accept) begin
            sr_d  = load_data;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            sr_d    = '0;
            cnt_d   = '0;
          end
        end
      end
    endcase

    // A bit is valid unless this edge froze the word on a held bit.
    busy_d = (state_d == SHIFT);
    x_d    = IDLE_LEVEL;
    if (busy_d) begin
      x_d = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
    end
    v_d  = busy_d && !((state_q == SHIFT) && hold);
    fd_d = v_d && (cnt_d == LAST);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      x_q     <= IDLE_LEVEL;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  assign x_out      = x_q;
  assign bit_valid  = v_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder.
// MSB-first and LSB-first instances share clock and reset.
module tb_serial_bit_feeder;

  logic       clock;
  logic       reset;
  logic       lv, hold;
  logic [7:0] ld;
  logic       ready, x, v, busy, fd;
  logic       lv2, hold2;
  logic [7:0] ld2;
  logic       ready2, x2, v2, busy2, fd2;

  int checks   = 0;
  int failures = 0;

  serial_bit_feeder #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
  ) u_msb (
    .clock(clock), .reset(reset),
    .load_valid(lv), .load_data(ld),
    .load_ready(ready), .hold(hold),
    .x_out(x), .bit_valid(v),
    .busy(busy), .frame_done(fd)
  );

  serial_bit_feeder #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
  ) u_lsb (
    .clock(clock), .reset(reset),
    .load_valid(lv2), .load_data(ld2),
    .load_ready(ready2), .hold(hold2),
    .x_out(x2), .bit_valid(v2),
    .busy(busy2), .frame_done(fd2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hold scenario on 8'hA5, cycles 1..13 after the accept edge.
  bit hx [1:13] = '{1,0,1,0,0,0,0,0,1,0,1,1,1};
  bit hv [1:13] = '{1,1,1,1,0,0,0,1,1,1,1,0,0};
  bit hf [1:13] = '{0,0,0,0,0,0,0,0,0,0,1,0,0};
  bit hh [1:13] = '{0,0,0,1,1,1,0,0,0,0,1,1,0};
  bit hr [1:13] = '{0,0,0,0,0,0,0,0,0,0,0,0,1};

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic ex,
                      input logic ev, input logic eb,
                      input logic ef);
    check({tag, ".x"}, 32'(x), 32'(ex));
    check({tag, ".v"}, 32'(v), 32'(ev));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".fd"}, 32'(fd), 32'(ef));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] seq;
    lv = 1'b1; ld = 8'hAA; hold = 1'b0;
    lv2 = 1'b1; ld2 = 8'h55; hold2 = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;

    // Reset held with load_valid high
    for (int i = 0; i < 3; i++) begin
      tick();
      outs($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst.lsb_busy", 32'(busy2), 32'd0);
    end
    lv = 1'b0; lv2 = 1'b0;
    reset = 1'b1;
    #1 check("rel.ready", 32'(ready), 32'd1);
    tick();
    outs("rel.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // MSB-first 8'hB4
    seq = 8'b10110100;
    lv = 1'b1; ld = 8'hB4;
    #1 check("b4.ready", 32'(ready), 32'd1);
    tick();
    lv = 1'b0; ld = 8'h00;
    for (int i = 0; i < 8; i++) begin
      outs($sformatf("b4.c%0d", i + 1), seq[7-i], 1'b1,
           1'b1, (i == 7));
      check($sformatf("b4.rdy%0d", i + 1), 32'(ready),
            32'(i == 7));
      tick();
    end
    outs("b4.end", 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back 8'hFF then 8'h00
    lv = 1'b1; ld = 8'hFF;
    tick();
    ld = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) lv = 1'b0;
      #1;
      outs($sformatf("bb.c%0d", i + 1), (i < 8), 1'b1,
           1'b1, (i == 7 || i == 15));
      check($sformatf("bb.rdy%0d", i + 1), 32'(ready),
            32'(i == 7 || i == 15));
      tick();
    end
    outs("bb.end", 1'b0, 1'b0, 1'b0, 1'b0);

    // Hold on bit 3 and on the last bit of 8'hA5
    lv = 1'b1; ld = 8'hA5;
    tick();
    lv = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      outs($sformatf("hd.c%0d", c), hx[c], hv[c], 1'b1, hf[c]);
      hold = hh[c];
      lv = (c == 11 || c == 12);
      ld = 8'hFF;
      #1;
      check($sformatf("hd.rdy%0d", c), 32'(ready), 32'(hr[c]));
      tick();
    end
    outs("hd.end", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of 8'hC3, then 8'h81
    seq = 8'b11000011;
    lv = 1'b1; ld = 8'hC3;
    tick();
    lv = 1'b0; ld = 8'h81;
    for (int i = 0; i < 4; i++) begin
      outs($sformatf("c3.c%0d", i + 1), seq[7-i], 1'b1,
           1'b1, 1'b0);
      if (i < 3) tick();
    end
    #2 reset = 1'b0;
    #1 outs("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    outs("mid.hold", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    seq = 8'b10000001;
    lv = 1'b1; ld = 8'h81;
    #1 check("81.ready", 32'(ready), 32'd1);
    tick();
    lv = 1'b0; ld = 8'h7E;
    for (int i = 0; i < 8; i++) begin
      outs($sformatf("81.c%0d", i + 1), seq[7-i], 1'b1,
           1'b1, (i == 7));
      tick();
    end
    outs("81.end", 1'b0, 1'b0, 1'b0, 1'b0);

    // LSB-first 8'hB4
    seq = 8'b00101101;
    lv2 = 1'b1; ld2 = 8'hB4;
    tick();
    lv2 = 1'b0; ld2 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lsb.x%0d", i + 1), 32'(x2),
            32'(seq[7-i]));
      check($sformatf("lsb.v%0d", i + 1), 32'(v2), 32'd1);
      check($sformatf("lsb.fd%0d", i + 1), 32'(fd2),
            32'(i == 7));
      tick();
    end
    check("lsb.end.x", 32'(x2), 32'd0);
    check("lsb.end.busy", 32'(busy2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
